// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit frame sequencer:
//   - tx_state_t : frame FSM state encoding
//   - MUX_*      : select codes driven to the downstream output mux
//   - PAR_*      : parity-type codes for PAR_TYP
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Output mux select codes; STOP doubles as the idle (line-high) code.
    localparam logic [1:0] MUX_START = 2'b00;
    localparam logic [1:0] MUX_STOP  = 2'b01;
    localparam logic [1:0] MUX_DATA  = 2'b10;
    localparam logic [1:0] MUX_PAR   = 2'b11;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage : uart_pkg

// File: rtl/uart_tx_serializer.sv
// ----------------------------------------------------------------------------
// uart_tx_serializer
// Holds the accepted payload and walks it out LSB-first, one bit per clock.
//
// Ports:
//   i_clk       in   1           baud clock
//   i_rst_n     in   1           asynchronous reset, active-low
//   i_load      in   1           latch i_data and clear the bit counter
//   i_shift_en  in   1           advance to the next bit (high during DATA)
//   i_data      in   DATA_WIDTH  payload to latch on i_load
//   o_ser_data  out  1           current payload bit (bit[cnt] of latched byte)
//   o_ser_done  out  1           high while the last payload bit is presented
// ----------------------------------------------------------------------------
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic                  i_shift_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ser_data,
    output logic                  o_ser_done
);

    localparam int             CW       = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_cnt;

    // A shift register keeps ser_data a direct flop output: bit[cnt] of the
    // latched byte always sits in r_shift[0].
    // NOTE: the payload register is reset too, so ser_data has a defined value
    // out of reset; it is a handful of flops, not a RAM, so the cost is nil.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_cnt   <= '0;
        end else if (i_shift_en) begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
            // Explicit wrap so non-power-of-two widths also return to 0.
            r_cnt   <= (r_cnt == LAST_BIT) ? '0 : r_cnt + CW'(1);
        end
    end

    assign o_ser_data = r_shift[0];
    // The counter only moves during DATA and sits at 0 otherwise; with
    // DATA_WIDTH >= 2 this compare is true only in the final DATA cycle.
    assign o_ser_done = (r_cnt == LAST_BIT);

endmodule : uart_tx_serializer

// File: rtl/uart_tx_ctrl.sv
// ----------------------------------------------------------------------------
// uart_tx_ctrl
// Frame sequencer for the UART transmitter. One CLK cycle per UART bit.
// Frame: start, DATA_WIDTH data bits LSB-first, optional parity, stop.
//
// Ports:
//   CLK         in   1           baud clock
//   RST         in   1           asynchronous reset, active-low
//   P_DATA      in   DATA_WIDTH  byte to send, sampled on acceptance
//   Data_Valid  in   1           send request (pulse or held)
//   PAR_EN      in   1           insert parity bit, sampled on acceptance
//   PAR_TYP     in   1           0 even / 1 odd, sampled on acceptance
//   mux_sel     out  2           00 start, 01 stop/idle, 10 data, 11 parity
//   ser_data    out  1           current data bit
//   par_bit     out  1           parity of the latched byte
//   busy        out  1           frame in progress
//
// Build option:
//   UART_TX_STOP2_EN  defined -> two stop bits; requests are accepted only in
//                     the second stop cycle.
// ----------------------------------------------------------------------------
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [1:0]            mux_sel,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic                  busy
);

    tx_state_t r_state;
    tx_state_t w_next_state;

    logic r_par_en;
    logic r_par_bit;
    logic w_accept;
    logic w_stop_last;
    logic w_shift_en;
    logic w_ser_done;

`ifdef UART_TX_STOP2_EN
    // Marks the second of the two stop cycles.
    logic r_stop_second;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_stop_second <= 1'b0;
        end else begin
            r_stop_second <= (r_state == ST_STOP) && !r_stop_second;
        end
    end

    assign w_stop_last = (r_state == ST_STOP) && r_stop_second;
`else
    assign w_stop_last = (r_state == ST_STOP);
`endif

    assign w_accept   = Data_Valid && ((r_state == ST_IDLE) || w_stop_last);
    assign w_shift_en = (r_state == ST_DATA);

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .i_clk      (CLK),
        .i_rst_n    (RST),
        .i_load     (w_accept),
        .i_shift_en (w_shift_en),
        .i_data     (P_DATA),
        .o_ser_data (ser_data),
        .o_ser_done (w_ser_done)
    );

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Parity settings are captured with the byte so mid-frame input changes
    // cannot affect the frame in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
        end else if (w_accept) begin
            r_par_en  <= PAR_EN;
            r_par_bit <= (PAR_TYP == PAR_ODD) ? ~(^P_DATA) : (^P_DATA);
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assigned first so every path drives the signal and no
        // latch is inferred.
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next_state = ST_START;
            ST_START:  w_next_state = ST_DATA;
            ST_DATA:   if (w_ser_done) w_next_state = r_par_en ? ST_PARITY : ST_STOP;
            ST_PARITY: w_next_state = ST_STOP;
            ST_STOP: begin
                if (w_stop_last) begin
                    // Back-to-back: a request in the final stop cycle skips IDLE.
                    w_next_state = w_accept ? ST_START : ST_IDLE;
                end
            end
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Outputs decoded from the state register only.
    always_comb begin
        mux_sel = MUX_STOP;
        case (r_state)
            ST_START:  mux_sel = MUX_START;
            ST_DATA:   mux_sel = MUX_DATA;
            ST_PARITY: mux_sel = MUX_PAR;
            default:   mux_sel = MUX_STOP;
        endcase
    end

    assign busy    = (r_state != ST_IDLE);
    assign par_bit = r_par_bit;

endmodule : uart_tx_ctrl

// File: tb/tb_uart_tx_ctrl.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Scoreboard bench for uart_tx_ctrl. Stimulus pushes the expected per-cycle
// frame (mux_sel plus data/parity bit) into a queue when it issues a request;
// a monitor pops one entry for every busy cycle and compares. Each entry also
// says whether the next cycle must still be busy, so early frame ends and
// gaps between back-to-back frames are caught.
// ----------------------------------------------------------------------------
module tb_uart_tx_ctrl;
    import uart_pkg::*;

    localparam int DW = 8;
`ifdef UART_TX_STOP2_EN
    localparam int STOP_CYC = 2;
`else
    localparam int STOP_CYC = 1;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [DW-1:0] P_DATA = '0;
    logic          Data_Valid = 1'b0;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic [1:0]    mux_sel;
    logic          ser_data;
    logic          par_bit;
    logic          busy;

    uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .mux_sel    (mux_sel),
        .ser_data   (ser_data),
        .par_bit    (par_bit),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0] mux;
        logic       bitv;
        logic       cont;   // next cycle must also be busy
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   expect_next = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        $display("FAIL %s: %s at %0t", name, what, $time);
    endtask

    // exp_par is the hand-computed parity bit for the vector.
    task automatic push_frame(input logic [7:0] d, input logic pe, input logic exp_par,
                              input logic b2b);
        exp_q.push_back('{mux: MUX_START, bitv: 1'b0, cont: 1'b1});
        for (int i = 0; i < DW; i++)
            exp_q.push_back('{mux: MUX_DATA, bitv: d[i], cont: 1'b1});
        if (pe)
            exp_q.push_back('{mux: MUX_PAR, bitv: exp_par, cont: 1'b1});
        for (int s = 0; s < STOP_CYC; s++)
            exp_q.push_back('{mux: MUX_STOP, bitv: 1'b0, cont: (s < STOP_CYC - 1) || b2b});
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                        input logic exp_par);
        @(posedge CLK); #1;
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Data_Valid = 1'b1;
        push_frame(d, pe, exp_par, 1'b0);
        @(posedge CLK); #1;
        Data_Valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge CLK); #1;
            if (!busy && exp_q.size() == 0) done = 1'b1;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                exp_q.delete();
                expect_next = 1'b0;
            end else if (busy) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_busy", "busy with no frame cycle expected");
                    expect_next = 1'b0;
                end else begin
                    e = exp_q.pop_front();
                    check("mux_sel", 32'(mux_sel), 32'(e.mux));
                    if (e.mux == MUX_DATA)     check("ser_data", 32'(ser_data), 32'(e.bitv));
                    else if (e.mux == MUX_PAR) check("par_bit", 32'(par_bit), 32'(e.bitv));
                    expect_next = e.cont;
                end
            end else begin
                if (expect_next) fail_now("frame_gap", "busy dropped while frame cycles remained");
                expect_next = 1'b0;
                check("idle_mux_sel", 32'(mux_sel), 32'(MUX_STOP));
            end
        end
    end

    // Watchdog
    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_mux_sel",  32'(mux_sel),  32'(MUX_STOP));
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_ser_data", 32'(ser_data), 32'd0);
        check("rst_par_bit",  32'(par_bit),  32'd0);
        @(posedge CLK); #1;
        RST = 1'b1;

        // 1: A5, no parity -> bits 1,0,1,0,0,1,0,1
        send(8'hA5, 1'b0, 1'b0, 1'b0);
        wait_idle("t1");

        // 2: 03 has two ones -> even parity 0, odd parity 1
        send(8'h03, 1'b1, PAR_EVEN, 1'b0);
        wait_idle("t2_even");
        send(8'h03, 1'b1, PAR_ODD, 1'b1);
        wait_idle("t2_odd");

        // 3: Data_Valid held, 55 then AA back-to-back
        @(posedge CLK); #1;
        P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        push_frame(8'h55, 1'b0, 1'b0, 1'b1);
        @(posedge CLK); #1;
        P_DATA = 8'hAA;
        push_frame(8'hAA, 1'b0, 1'b0, 1'b0);
        repeat (1 + DW + STOP_CYC) @(posedge CLK);
        #1;
        Data_Valid = 1'b0;
        wait_idle("t3");

        // 4: request during DATA bit 3 is ignored; frame 5A completes unchanged
        send(8'h5A, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge CLK);
        #1;
        P_DATA = 8'hFF; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_Valid = 1'b1;
        @(posedge CLK); #1;
        Data_Valid = 1'b0;
        wait_idle("t4");

        // 5: reset during DATA bit 4, then a clean frame (96 has four ones, odd -> 1)
        send(8'hC3, 1'b0, 1'b0, 1'b0);
        repeat (5) @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        check("abort_mux_sel",  32'(mux_sel),  32'(MUX_STOP));
        check("abort_busy",     32'(busy),     32'd0);
        check("abort_ser_data", 32'(ser_data), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        send(8'h96, 1'b1, PAR_ODD, 1'b1);
        wait_idle("t5");

        // 6: 00 without parity (two stop cycles in the two-stop build)
        send(8'h00, 1'b0, 1'b0, 1'b0);
        wait_idle("t6");

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_uart_tx_ctrl
